// File: rtl/mips_pkg.sv
// Shared MIPS fetch-side types: instruction-fetch FSM states and the default bubble instruction.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_if.sv
// Single-entry instruction hold register in front of a req/gnt/rvalid instruction memory.
// Presents the instruction for pcF or stalls fetch while one miss is outstanding.
module imem_fetch_if
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  input  logic        stallF,
  output logic [31:0] instrF,
  output logic        fetch_stall,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [15:0] miss_count
);

  fetch_state_e state_q, state_d;
  logic [29:0]  req_addr_q, req_addr_d;
  logic         hold_valid_q, hold_valid_d;
  logic [29:0]  hold_addr_q, hold_addr_d;
  logic [31:0]  hold_data_q, hold_data_d;
  logic [15:0]  miss_cnt_q, miss_cnt_d;

  logic [29:0]  pc_word;
  logic         hit;

  // stallF and the byte offset are observed but deliberately have no effect.
  logic         unused_inputs;
  assign unused_inputs = stallF ^ pcF[1] ^ pcF[0];

  assign pc_word = pcF[31:2];
  assign hit     = hold_valid_q && (hold_addr_q == pc_word);

  always_comb begin
    instrF      = hit ? hold_data_q : NOP_INSTR;
    fetch_stall = ~hit;
    miss_count  = miss_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    miss_cnt_d   = miss_cnt_q;
    imem_req     = 1'b0;
    imem_addr    = '0;

    case (state_q)
      StIdle: begin
        if (!hit) begin
          req_addr_d = pc_word;
          state_d    = StReq;
        end
      end
      StReq: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_gnt) begin
          state_d = StWait;
          if (miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          // Data for a PC the datapath has moved away from is dropped.
          if (req_addr_q == pc_word) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = req_addr_q;
            hold_data_d  = imem_rdata;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_if.sv
// Directed bench for imem_fetch_if: inputs change on the falling edge, outputs checked 1ns later.
module tb_imem_fetch_if;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pcF = 32'h0;
  logic        stallF = 1'b0;
  logic [31:0] instrF;
  logic        fetch_stall;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_mis = 0;

  imem_fetch_if dut (
    .clk         (clk),
    .reset       (reset),
    .pcF         (pcF),
    .stallF      (stallF),
    .instrF      (instrF),
    .fetch_stall (fetch_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic reset_dut(input logic [31:0] pc);
    nxt();
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    pcF         = pc;
    nxt();
    nxt();
    reset = 1'b0;
    #1;
    chk("rst_stall", {31'b0, fetch_stall}, 32'd1);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", {2'b0, imem_addr}, 32'd0);
    chk("rst_instr", instrF, 32'h0);
    chk("rst_cnt", {16'b0, miss_count}, 32'd0);
  endtask

  // Fastest miss: gnt on the first REQ cycle, rvalid on the first WAIT cycle.
  task automatic do_miss(input logic [31:0] pc, input logic [15:0] exp_cnt);
    nxt();
    pcF = pc;
    #1 chk("miss_stall", {31'b0, fetch_stall}, 32'd1);
    nxt();
    imem_gnt = 1'b1;
    #1 chk("miss_req", {31'b0, imem_req}, 32'd1);
    chk("miss_addr", {2'b0, imem_addr}, {2'b0, pc[31:2]});
    nxt();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = ~pc;
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("miss_instr", instrF, ~pc);
    chk("miss_cnt", {16'b0, miss_count}, {16'b0, exp_cnt});
  endtask

  initial begin
    // Basic miss with minimum latency.
    reset_dut(32'h0040_0000);
    nxt();
    imem_gnt = 1'b1;
    #1 chk("s1_req", {31'b0, imem_req}, 32'd1);
    chk("s1_addr", {2'b0, imem_addr}, 32'h0010_0000);
    chk("s1_stall_req", {31'b0, fetch_stall}, 32'd1);
    nxt();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2008_000A;
    #1 chk("s1_req_wait", {31'b0, imem_req}, 32'd0);
    chk("s1_stall_wait", {31'b0, fetch_stall}, 32'd1);
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("s1_stall_hit", {31'b0, fetch_stall}, 32'd0);
    chk("s1_instr", instrF, 32'h2008_000A);
    chk("s1_cnt", {16'b0, miss_count}, 32'd1);

    // Hit held while stallF toggles: no traffic.
    for (int i = 0; i < 4; i++) begin
      nxt();
      stallF = ~stallF;
      #1 chk("s5_req", {31'b0, imem_req}, 32'd0);
      chk("s5_stall", {31'b0, fetch_stall}, 32'd0);
      chk("s5_cnt", {16'b0, miss_count}, 32'd1);
    end
    stallF = 1'b0;

    // Grant withheld for 4 cycles.
    reset_dut(32'h0040_0000);
    for (int i = 0; i < 4; i++) begin
      nxt();
      #1 chk("s2_req", {31'b0, imem_req}, 32'd1);
      chk("s2_addr", {2'b0, imem_addr}, 32'h0010_0000);
      chk("s2_cnt", {16'b0, miss_count}, 32'd0);
    end
    nxt();
    imem_gnt = 1'b1;
    #1 chk("s2_req_gnt", {31'b0, imem_req}, 32'd1);
    nxt();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    #1 chk("s2_cnt_gnt", {16'b0, miss_count}, 32'd1);
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("s2_instr", instrF, 32'h1111_1111);

    // Redirect during WAIT: stale data dropped, new miss issued.
    reset_dut(32'h0040_0000);
    nxt();
    imem_gnt = 1'b1;
    nxt();
    imem_gnt    = 1'b0;
    pcF         = 32'h0040_0010;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1 chk("s3_stall_wait", {31'b0, fetch_stall}, 32'd1);
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("s3_stale_stall", {31'b0, fetch_stall}, 32'd1);
    chk("s3_stale_instr", instrF, 32'h0);
    chk("s3_idle_req", {31'b0, imem_req}, 32'd0);
    nxt();
    imem_gnt = 1'b1;
    #1 chk("s3_req2", {31'b0, imem_req}, 32'd1);
    chk("s3_addr2", {2'b0, imem_addr}, 32'h0010_0004);
    nxt();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h8C09_0004;
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("s3_instr", instrF, 32'h8C09_0004);
    chk("s3_cnt", {16'b0, miss_count}, 32'd2);

    // Return to held PC while a different miss is outstanding.
    nxt();
    pcF = 32'h0040_0020;
    #1 chk("s25_miss", {31'b0, fetch_stall}, 32'd1);
    nxt();
    pcF      = 32'h0040_0010;
    imem_gnt = 1'b1;
    #1 chk("s25_hit_stall", {31'b0, fetch_stall}, 32'd0);
    chk("s25_hit_instr", instrF, 32'h8C09_0004);
    chk("s25_req", {31'b0, imem_req}, 32'd1);
    chk("s25_addr", {2'b0, imem_addr}, 32'h0010_0008);
    nxt();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h5555_5555;
    #1 chk("s25_wait_stall", {31'b0, fetch_stall}, 32'd0);
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("s25_instr", instrF, 32'h8C09_0004);
    chk("s25_cnt", {16'b0, miss_count}, 32'd3);
    chk("s25_idle_req", {31'b0, imem_req}, 32'd0);

    // Reset in WAIT, late rvalid ignored.
    reset_dut(32'h0040_0040);
    nxt();
    imem_gnt = 1'b1;
    nxt();
    imem_gnt = 1'b0;
    reset    = 1'b1;
    nxt();
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0BAD;
    #1 chk("s4_stall", {31'b0, fetch_stall}, 32'd1);
    chk("s4_req", {31'b0, imem_req}, 32'd0);
    chk("s4_cnt", {16'b0, miss_count}, 32'd0);
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("s4_req2", {31'b0, imem_req}, 32'd1);
    chk("s4_addr2", {2'b0, imem_addr}, 32'h0010_0010);
    chk("s4_instr", instrF, 32'h0);
    nxt();
    imem_gnt = 1'b1;
    nxt();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0042;
    nxt();
    imem_rvalid = 1'b0;
    #1 chk("s4_instr2", instrF, 32'h0000_0042);
    chk("s4_cnt2", {16'b0, miss_count}, 32'd1);

    // Saturation: preload the counter close to the top, then keep missing.
    nxt();
    force dut.miss_cnt_q = 16'hFFFD;
    #1 release dut.miss_cnt_q;
    #1 chk("s6_preload", {16'b0, miss_count}, 32'h0000_FFFD);
    do_miss(32'h0040_1000, 16'hFFFE);
    do_miss(32'h0040_1004, 16'hFFFF);
    do_miss(32'h0040_1008, 16'hFFFF);
    do_miss(32'h0040_100C, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/imem_fetch_if.md
IMEM_FETCH_IF -- requirements
Module: imem_fetch_if

Interface
REQ-001 Parameter: NOP_INSTR, 32'h00000000, instruction driven on instrF while fetch_stall is high.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 pcF  in  32  current fetch PC from datapath; word address is pcF[31:2], bits [1:0] ignored.
REQ-005 stallF  in  1  hazard-unit fetch stall; informational only, no effect on FSM.
REQ-006 instrF  out  32  instruction for current pcF; valid when fetch_stall low.
REQ-007 fetch_stall  out  1  high when instrF does not hold the instruction for current pcF; ORed into stallF by the hazard unit.
REQ-008 imem_req  out  1  memory request strobe.
REQ-009 imem_addr  out  30  word address of request.
REQ-010 imem_gnt  in  1  memory accepts request this cycle.
REQ-011 imem_rvalid  in  1  read data valid; earliest one cycle after gnt.
REQ-012 imem_rdata  in  32  read data.
REQ-013 miss_count  out  16  saturating count of issued requests.

Function
REQ-014 Hold register: hold_valid, hold_addr[29:0], hold_data[31:0].
REQ-015 Hit = hold_valid AND hold_addr == pcF[31:2]; combinational from registered state and pcF.
REQ-016 On hit: instrF = hold_data, fetch_stall = 0; otherwise instrF = NOP_INSTR, fetch_stall = 1.
REQ-017 FSM states IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-018 IDLE: on miss, latch req_addr = pcF[31:2], go REQ; on hit, stay IDLE.
REQ-019 REQ: imem_req = 1, imem_addr = req_addr, both stable until imem_gnt; on gnt go WAIT and increment miss_count (saturate at 16'hFFFF).
REQ-020 WAIT: imem_req = 0; on imem_rvalid, if req_addr == pcF[31:2] load hold_addr = req_addr, hold_data = imem_rdata, hold_valid = 1; else discard (stale); go IDLE in both cases.
REQ-021 imem_req = 0 and imem_addr = 0 outside REQ.
REQ-022 pcF change while in REQ or WAIT (redirect/jump): no bus abort; transaction completes and is discarded per REQ-020; new miss issued from IDLE.
REQ-023 imem_rvalid in IDLE or REQ is ignored; no state change.
REQ-024 Minimum miss latency: miss seen cycle t, REQ with gnt at t+1, rvalid at t+2, hit at t+3 -> fetch_stall high 3 cycles.
REQ-025 pcF returning to hold_addr while in REQ/WAIT hits immediately; outstanding transaction still completes and overwrites hold only if address matches.

Reset
REQ-026 On reset: state = IDLE, hold_valid = 0, hold_addr = 0, hold_data = 0, req_addr = 0, miss_count = 0.
REQ-027 Outputs after reset: imem_req = 0, imem_addr = 0, fetch_stall = 1, instrF = NOP_INSTR.
REQ-028 Reset mid-transaction abandons it; a late imem_rvalid after reset falls under REQ-023.

Structure
REQ-029 FSM state enum and NOP_INSTR default belong in shared package mips_pkg.
REQ-030 Single module; no sub-module required.

Verification
REQ-031 Reset, pcF=0x00400000, gnt same cycle as req, rvalid +1 with 0x2008000A -> fetch_stall 3 cycles, then instrF=0x2008000A, miss_count=1.
REQ-032 Hold gnt low 4 cycles in REQ -> imem_req=1, imem_addr=0x00100000 stable all 4 cycles; miss_count increments only on gnt.
REQ-033 pcF 0x00400000 -> 0x00400010 during WAIT; rvalid with stale data -> data discarded, new req addr 0x00100004, final instrF matches 0x00400010 data.
REQ-034 Reset asserted in WAIT, rvalid next cycle -> ignored, hold_valid=0, state IDLE then new request for current pcF.
REQ-035 Same pcF held across hit, stallF toggled -> no requests, fetch_stall=0, miss_count unchanged.
REQ-036 Force miss_count to 16'hFFFF via repeated misses -> stays 16'hFFFF on further grants.
